tspi_tx_arb: RTL and testbench
==============================

Name: tspi_tx_arb

Overview:
Two-requester round-robin arbiter and frame sequencer in front of the SPI byte transmitter (txd_en/txd_cmpt/tx_dreq/tx_valid/tx_data/tx_div interface). Each requester submits a frame of N bytes plus its own clock divider. The block grants the transmitter to one requester at a time and runs one transmitter transaction per byte. A watchdog aborts a frame if the transmitter stalls.

Parameters:
SPI0_0, 8, data byte width
SPI0_1, 32, clock divider width
LEN_W, 8, frame length field width; value 0 means 2^LEN_W bytes
TIMEOUT, 65535, watchdog limit in clk cycles per wait phase (must be >= 1, fits 16 bits)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
rq0_req  in  1  requester 0 frame request (level)
rq0_len  in  LEN_W  requester 0 byte count, sampled at grant
rq0_div  in  SPI0_1  requester 0 divider, sampled at grant
rq0_data  in  SPI0_0  requester 0 byte
rq0_dvalid  in  1  requester 0 byte valid
rq0_dready  out  1  requester 0 byte accept
rq0_gnt  out  1  requester 0 owns transmitter
rq0_done  out  1  1-cycle pulse, frame finished
rq0_err  out  1  1-cycle pulse, frame aborted by watchdog
rq1_*  (same set, same widths)  requester 1
txd_en  out  1  1-cycle start pulse, one byte transaction
txd_cmpt  in  1  1-cycle pulse, byte shifted out
tx_dreq  in  1  1-cycle pulse, transmitter wants byte
tx_valid  out  1  1-cycle pulse, tx_data valid
tx_data  out  SPI0_0  byte to transmitter
tx_div  out  SPI0_1  divider, stable for the whole frame

Behaviour:
- Reset (rst=0, async): every output 0, tx_div=0, state IDLE, count=0, watchdog=0, rr pointer = 1 (so requester 0 wins the first tie).
- States: IDLE, GRANT, START, WAIT_DREQ, FETCH, SEND, WAIT_CMPT, NEXT, DONE, ABORT.
- IDLE: if any rqN_req, pick winner (single requester wins; both -> the one != rr pointer) -> GRANT. Latency: req sampled at cycle t, gnt high at t+1, txd_en at t+2.
- GRANT: gnt of winner =1 (held through DONE/ABORT); latch len into 9-bit count (0 -> 256 for LEN_W=8); tx_div <= rqN_div -> START.
- START: txd_en=1 for exactly 1 cycle; clear watchdog -> WAIT_DREQ.
- WAIT_DREQ: on tx_dreq -> FETCH. Watchdog reaching TIMEOUT -> ABORT.
- FETCH: rqN_dready=1 (combinational from state); on rqN_dvalid&dready capture rqN_data into tx_data -> SEND. No watchdog here; requester must supply data.
- SEND: tx_valid=1 for 1 cycle with captured tx_data; clear watchdog -> WAIT_CMPT.
- WAIT_CMPT: on txd_cmpt -> NEXT. Watchdog reaching TIMEOUT -> ABORT.
- NEXT: count-1; if result 0 -> DONE else -> START.
- DONE: rqN_done=1 for 1 cycle; gnt drops next cycle; rr pointer <= granted index -> IDLE.
- ABORT: rqN_err=1 for 1 cycle, no done; remaining bytes discarded; rr pointer <= granted index -> IDLE.
- tx_dreq outside WAIT_DREQ and txd_cmpt outside WAIT_CMPT: ignored. tx_dreq and txd_cmpt in the same cycle: only the one matching the current state is acted on.
- rqN_req dropped mid-frame: ignored, frame runs to completion. rq_len/rq_div changes after GRANT: ignored.
- Losing requester's dready, gnt, done and err stay 0 throughout.
- Requester holding req high after done: re-arbitrates in IDLE; the other pending requester wins (strict alternation under contention).
- At most one gnt high at any time. done and err never pulse in the same frame.

Test Plan:
- rq0 len=1 div=4, data 0xA5 -> gnt0 at t+1, one txd_en, tx_valid with 0xA5, tx_div=4 throughout, done0 one cycle after txd_cmpt+NEXT, rr=0.
- rq1 len=3 bytes 0x11,0x22,0x33, transmitter model returns dreq/cmpt -> exactly 3 txd_en pulses, tx_data sequence 11,22,33, single done1.
- rq0 and rq1 asserted in the same cycle after reset, both held -> frames ordered 0,1,0,1. gnt never overlaps. Each tx_div matches its owner.
- rq0 len=0 -> 256 txd_en/tx_valid pairs, then done0.
- TIMEOUT=16, transmitter never asserts txd_cmpt -> err0 exactly 17 cycles after the SEND cycle, no done0, IDLE, rq1 served next.
- rst pulled low during WAIT_CMPT of byte 2 -> all outputs 0 immediately. After release, new rq0 frame is granted from IDLE with rr=1.

Source files
------------

// File: rtl/tspi_tx_arb.sv
// tspi_tx_arb: two-requester round-robin arbiter and frame sequencer feeding
// the SPI byte transmitter. One transmitter transaction per byte; a watchdog
// aborts the frame if the transmitter stalls in either wait phase.
module tspi_tx_arb #(
  parameter int SPI0_0  = 8,      // data byte width
  parameter int SPI0_1  = 32,     // clock divider width
  parameter int LEN_W   = 8,      // frame length width, 0 encodes 2^LEN_W
  parameter int TIMEOUT = 65535   // watchdog limit per wait phase, 1..65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rq0_req,
  input  logic [LEN_W-1:0]  rq0_len,
  input  logic [SPI0_1-1:0] rq0_div,
  input  logic [SPI0_0-1:0] rq0_data,
  input  logic              rq0_dvalid,
  output logic              rq0_dready,
  output logic              rq0_gnt,
  output logic              rq0_done,
  output logic              rq0_err,
  input  logic              rq1_req,
  input  logic [LEN_W-1:0]  rq1_len,
  input  logic [SPI0_1-1:0] rq1_div,
  input  logic [SPI0_0-1:0] rq1_data,
  input  logic              rq1_dvalid,
  output logic              rq1_dready,
  output logic              rq1_gnt,
  output logic              rq1_done,
  output logic              rq1_err,
  output logic              txd_en,
  input  logic              txd_cmpt,
  input  logic              tx_dreq,
  output logic              tx_valid,
  output logic [SPI0_0-1:0] tx_data,
  output logic [SPI0_1-1:0] tx_div
);

  typedef enum logic [3:0] {
    IDLE, GRANT, START, WAIT_DREQ, FETCH, SEND, WAIT_CMPT, NEXT, DONE, ABORT
  } state_t;

  // Length 0 stands for a full 2^LEN_W byte frame.
  localparam logic [LEN_W:0] FULL = {1'b1, {LEN_W{1'b0}}};
  localparam logic [15:0]    TO   = 16'(TIMEOUT);

  state_t                        state;
  logic                          idx;   // granted requester
  logic                          rr;    // last served requester
  logic [LEN_W:0]                cnt;   // bytes left in frame
  logic [15:0]                   wd;    // watchdog, cycles in current wait
  logic [1:0]                    gnt;
  logic [1:0]                    done;
  logic [1:0]                    err;

  // Requester inputs gathered into index-able arrays.
  logic [1:0]                    req;
  logic [1:0]                    dvalid;
  logic [1:0][LEN_W-1:0]         len;
  logic [1:0][SPI0_1-1:0]        div;
  logic [1:0][SPI0_0-1:0]        data;

  assign req    = {rq1_req, rq0_req};
  assign dvalid = {rq1_dvalid, rq0_dvalid};
  assign len    = {rq1_len, rq0_len};
  assign div    = {rq1_div, rq0_div};
  assign data   = {rq1_data, rq0_data};

  assign rq0_gnt  = gnt[0];
  assign rq1_gnt  = gnt[1];
  assign rq0_done = done[0];
  assign rq1_done = done[1];
  assign rq0_err  = err[0];
  assign rq1_err  = err[1];

  // Byte accept is only offered to the owner while fetching.
  assign rq0_dready = (state == FETCH) && !idx;
  assign rq1_dready = (state == FETCH) &&  idx;

  logic        pick;
  logic [1:0]  own;
  logic [15:0] wd_nxt;
  logic        wd_hit;

  // Winner selection: a lone requester wins; on a tie the one not served last.
  always_comb begin
    pick = req[1];
    if (req == 2'b11) pick = ~rr;
  end

  assign own    = idx ? 2'b10 : 2'b01;
  assign wd_nxt = wd + 16'd1;
  assign wd_hit = (wd_nxt == TO);

  // Frame sequencer with registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= 1'b0;
      rr       <= 1'b1;
      cnt      <= '0;
      wd       <= '0;
      gnt      <= '0;
      done     <= '0;
      err      <= '0;
      txd_en   <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      tx_div   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            idx   <= pick;
            gnt   <= pick ? 2'b10 : 2'b01;
            state <= GRANT;
          end
        end
        GRANT: begin
          cnt    <= (len[idx] == '0) ? FULL : {1'b0, len[idx]};
          tx_div <= div[idx];
          txd_en <= 1'b1;
          state  <= START;
        end
        START: begin
          txd_en <= 1'b0;
          wd     <= '0;
          state  <= WAIT_DREQ;
        end
        WAIT_DREQ: begin
          if (tx_dreq) begin
            state <= FETCH;
          end else if (wd_hit) begin
            err   <= own;
            state <= ABORT;
          end else begin
            wd <= wd_nxt;
          end
        end
        FETCH: begin
          // No watchdog: the requester is obliged to supply the byte.
          if (dvalid[idx]) begin
            tx_data  <= data[idx];
            tx_valid <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          tx_valid <= 1'b0;
          wd       <= '0;
          state    <= WAIT_CMPT;
        end
        WAIT_CMPT: begin
          if (txd_cmpt) begin
            state <= NEXT;
          end else if (wd_hit) begin
            err   <= own;
            state <= ABORT;
          end else begin
            wd <= wd_nxt;
          end
        end
        NEXT: begin
          cnt <= cnt - 1'b1;
          if (cnt == {{LEN_W{1'b0}}, 1'b1}) begin
            done  <= own;
            state <= DONE;
          end else begin
            txd_en <= 1'b1;
            state  <= START;
          end
        end
        DONE: begin
          done  <= '0;
          gnt   <= '0;
          rr    <= idx;
          state <= IDLE;
        end
        ABORT: begin
          // Remaining bytes of the frame are simply dropped.
          err   <= '0;
          gnt   <= '0;
          rr    <= idx;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tspi_tx_arb.sv
// Directed bench for tspi_tx_arb with a small transmitter responder.
module tb_tspi_tx_arb;
  logic        clk = 0;
  logic        rst;
  logic        rq0_req, rq0_dvalid, rq0_dready, rq0_gnt, rq0_done, rq0_err;
  logic        rq1_req, rq1_dvalid, rq1_dready, rq1_gnt, rq1_done, rq1_err;
  logic [7:0]  rq0_len, rq1_len, rq0_data, rq1_data, tx_data;
  logic [31:0] rq0_div, rq1_div, tx_div;
  logic        txd_en, txd_cmpt, tx_dreq, tx_valid;

  tspi_tx_arb #(.SPI0_0(8), .SPI0_1(32), .LEN_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .rq0_req(rq0_req), .rq0_len(rq0_len), .rq0_div(rq0_div), .rq0_data(rq0_data),
    .rq0_dvalid(rq0_dvalid), .rq0_dready(rq0_dready), .rq0_gnt(rq0_gnt),
    .rq0_done(rq0_done), .rq0_err(rq0_err),
    .rq1_req(rq1_req), .rq1_len(rq1_len), .rq1_div(rq1_div), .rq1_data(rq1_data),
    .rq1_dvalid(rq1_dvalid), .rq1_dready(rq1_dready), .rq1_gnt(rq1_gnt),
    .rq1_done(rq1_done), .rq1_err(rq1_err),
    .txd_en(txd_en), .txd_cmpt(txd_cmpt), .tx_dreq(tx_dreq), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_div(tx_div)
  );

  always #5 clk = ~clk;

  int checks = 0, passed = 0, fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Requester byte sources: each accepted byte advances the read index.
  logic [7:0] bytes0 [256];
  logic [7:0] bytes1 [256];
  logic [7:0] idx0, idx1;
  assign rq0_data = bytes0[idx0];
  assign rq1_data = bytes1[idx1];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx0 <= 0;
      idx1 <= 0;
    end else begin
      if (rq0_dready && rq0_dvalid) idx0 <= idx0 + 8'd1;
      if (rq1_dready && rq1_dvalid) idx1 <= idx1 + 8'd1;
    end
  end

  // Monitor plus transmitter responder, evaluated mid-cycle.
  int         cyc = 0, en_cnt = 0, val_cnt = 0, fr_cnt = 0;
  int         done0_cnt = 0, done1_cnt = 0, err0_cnt = 0, err1_cnt = 0;
  int         ovl = 0, div_bad = 0, lose_bad = 0;
  int         cmpt_cyc = 0, done_cyc = 0, valid_cyc = 0, err_cyc = 0;
  int         dcnt = 0, ccnt = 0;
  logic       cmpt_en;
  logic [31:0] exp_div0, exp_div1;
  logic [7:0] data_q [$];
  int         owner_q [$];

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      dcnt = 0; ccnt = 0; tx_dreq = 0; txd_cmpt = 0;
    end else begin
      if (txd_en) en_cnt++;
      if (tx_valid) begin val_cnt++; valid_cyc = cyc; data_q.push_back(tx_data); end
      if (rq0_done) begin done0_cnt++; fr_cnt++; done_cyc = cyc; owner_q.push_back(0); end
      if (rq1_done) begin done1_cnt++; fr_cnt++; done_cyc = cyc; owner_q.push_back(1); end
      if (rq0_err) begin err0_cnt++; fr_cnt++; err_cyc = cyc; end
      if (rq1_err) begin err1_cnt++; fr_cnt++; err_cyc = cyc; end
      if (rq0_gnt && rq1_gnt) ovl++;
      if (txd_en && rq0_gnt && tx_div != exp_div0) div_bad++;
      if (txd_en && rq1_gnt && tx_div != exp_div1) div_bad++;
      if (!rq0_gnt && (rq0_dready || rq0_done || rq0_err)) lose_bad++;
      if (!rq1_gnt && (rq1_dready || rq1_done || rq1_err)) lose_bad++;
      tx_dreq = 0; txd_cmpt = 0;
      if (dcnt > 0) begin dcnt--; if (dcnt == 0) tx_dreq = 1; end
      if (ccnt > 0) begin
        ccnt--;
        if (ccnt == 0 && cmpt_en) begin txd_cmpt = 1; cmpt_cyc = cyc; end
      end
      if (txd_en) dcnt = 2;
      if (tx_valid) ccnt = 3;
    end
  end

  task automatic wait_frames(input int tgt, input int budget, input string tag);
    int n = 0;
    while (fr_cnt < tgt && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk(tag, 64'(fr_cnt >= tgt), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  int b, e, v, f, d0, d1, r0, ob;

  initial begin
    rst = 0; cmpt_en = 1; exp_div0 = 0; exp_div1 = 0;
    rq0_req = 0; rq0_len = 0; rq0_div = 0; rq0_dvalid = 1;
    rq1_req = 0; rq1_len = 0; rq1_div = 0; rq1_dvalid = 1;
    tx_dreq = 0; txd_cmpt = 0;
    for (int i = 0; i < 256; i++) begin bytes0[i] = 0; bytes1[i] = 0; end
    repeat (3) @(negedge clk);
    chk("rst_gnt0", rq0_gnt, 0);
    chk("rst_txd_en", txd_en, 0);
    chk("rst_tx_div", tx_div, 0);
    chk("rst_rr", dut.rr, 1);
    chk("rst_state", 64'(dut.state), 0);
    rst = 1;
    @(negedge clk);

    // T1: single byte frame from requester 0.
    b = data_q.size(); e = en_cnt; f = fr_cnt; d0 = done0_cnt;
    bytes0[idx0] = 8'hA5; rq0_len = 1; rq0_div = 4; exp_div0 = 4; rq0_req = 1;
    @(posedge clk); #1;
    chk("t1_gnt_t1", rq0_gnt, 1);
    chk("t1_en_t1", txd_en, 0);
    @(posedge clk); #1;
    chk("t1_en_t2", txd_en, 1);
    chk("t1_div", tx_div, 4);
    wait_frames(f + 1, 200, "t1_wait");
    rq0_req = 0;
    chk("t1_en_cnt", 64'(en_cnt - e), 1);
    chk("t1_data", data_q[b], 8'hA5);
    chk("t1_done_lat", 64'(done_cyc - cmpt_cyc), 2);
    chk("t1_done_cnt", 64'(done0_cnt - d0), 1);
    @(negedge clk);
    chk("t1_rr", dut.rr, 0);
    chk("t1_gnt_drop", rq0_gnt, 0);

    // T2: three byte frame from requester 1.
    b = data_q.size(); e = en_cnt; v = val_cnt; f = fr_cnt; d0 = done0_cnt; d1 = done1_cnt;
    bytes1[8'(idx1 + 0)] = 8'h11; bytes1[8'(idx1 + 1)] = 8'h22; bytes1[8'(idx1 + 2)] = 8'h33;
    rq1_len = 3; rq1_div = 9; exp_div1 = 9; rq1_req = 1;
    wait_frames(f + 1, 300, "t2_wait");
    rq1_req = 0;
    chk("t2_en_cnt", 64'(en_cnt - e), 3);
    chk("t2_val_cnt", 64'(val_cnt - v), 3);
    chk("t2_data0", data_q[b], 8'h11);
    chk("t2_data1", data_q[b + 1], 8'h22);
    chk("t2_data2", data_q[b + 2], 8'h33);
    chk("t2_done1", 64'(done1_cnt - d1), 1);
    chk("t2_no_done0", 64'(done0_cnt - d0), 0);
    @(negedge clk);
    chk("t2_rr", dut.rr, 1);

    // T3: contention, both held: strict alternation 0,1,0,1.
    ob = owner_q.size(); e = en_cnt; f = fr_cnt;
    for (int i = 0; i < 4; i++) begin
      bytes0[8'(idx0 + i)] = 8'hC0 + 8'(i);
      bytes1[8'(idx1 + i)] = 8'hD0 + 8'(i);
    end
    rq0_len = 1; rq0_div = 7; exp_div0 = 7;
    rq1_len = 2; rq1_div = 9; exp_div1 = 9;
    rq0_req = 1; rq1_req = 1;
    wait_frames(f + 4, 400, "t3_wait");
    rq0_req = 0; rq1_req = 0;
    chk("t3_own0", 64'(owner_q[ob]), 0);
    chk("t3_own1", 64'(owner_q[ob + 1]), 1);
    chk("t3_own2", 64'(owner_q[ob + 2]), 0);
    chk("t3_own3", 64'(owner_q[ob + 3]), 1);
    chk("t3_en_cnt", 64'(en_cnt - e), 6);
    chk("t3_overlap", 64'(ovl), 0);
    chk("t3_div", 64'(div_bad), 0);
    @(negedge clk);

    // T4: length 0 means 256 bytes.
    b = data_q.size(); e = en_cnt; v = val_cnt; f = fr_cnt; d0 = done0_cnt;
    for (int i = 0; i < 256; i++) bytes0[8'(idx0 + i)] = 8'(i);
    rq0_len = 0; rq0_div = 3; exp_div0 = 3; rq0_req = 1;
    wait_frames(f + 1, 4000, "t4_wait");
    rq0_req = 0;
    chk("t4_en_cnt", 64'(en_cnt - e), 256);
    chk("t4_val_cnt", 64'(val_cnt - v), 256);
    chk("t4_first", data_q[b], 8'h00);
    chk("t4_last", data_q[b + 255], 8'hFF);
    chk("t4_done0", 64'(done0_cnt - d0), 1);
    @(negedge clk);

    // T5: transmitter never completes -> watchdog abort, then rq1 served.
    cmpt_en = 0;
    e = en_cnt; f = fr_cnt; d0 = done0_cnt; d1 = done1_cnt; r0 = err0_cnt;
    bytes0[idx0] = 8'h77; bytes0[8'(idx0 + 1)] = 8'h78;
    rq0_len = 2; rq0_div = 5; exp_div0 = 5; rq0_req = 1;
    @(posedge clk); #1;
    chk("t5_gnt0", rq0_gnt, 1);
    bytes1[idx1] = 8'h5A; rq1_len = 1; rq1_div = 6; exp_div1 = 6; rq1_req = 1;
    wait_frames(f + 1, 200, "t5_abort");
    rq0_req = 0; cmpt_en = 1;
    chk("t5_err0", 64'(err0_cnt - r0), 1);
    chk("t5_no_done0", 64'(done0_cnt - d0), 0);
    chk("t5_err_lat", 64'(err_cyc - valid_cyc), 17);
    chk("t5_en_cnt", 64'(en_cnt - e), 1);
    @(negedge clk);
    chk("t5_idle", 64'(dut.state), 0);
    chk("t5_gnt0_drop", rq0_gnt, 0);
    wait_frames(f + 2, 300, "t5_rq1");
    rq1_req = 0;
    chk("t5_owner", 64'(owner_q[$]), 1);
    chk("t5_done1", 64'(done1_cnt - d1), 1);
    chk("t5_data", data_q[$], 8'h5A);
    @(negedge clk);

    // T6: asynchronous reset during WAIT_CMPT of byte 2.
    v = val_cnt;
    for (int i = 0; i < 3; i++) bytes0[8'(idx0 + i)] = 8'h90 + 8'(i);
    rq0_len = 3; rq0_div = 8; exp_div0 = 8; rq0_req = 1;
    for (int n = 0; n < 200 && (val_cnt - v) < 2; n++) begin @(negedge clk); #1; end
    chk("t6_second_send", 64'(val_cnt - v >= 2), 1);
    @(negedge clk); #1;
    chk("t6_wait_cmpt", 64'(dut.state), 6);
    rst = 0; #1;
    chk("t6_rst_gnt0", rq0_gnt, 0);
    chk("t6_rst_valid", tx_valid, 0);
    chk("t6_rst_data", tx_data, 0);
    chk("t6_rst_div", tx_div, 0);
    chk("t6_rst_state", 64'(dut.state), 0);
    chk("t6_rst_rr", dut.rr, 1);
    repeat (2) @(negedge clk);
    rst = 1;
    f = fr_cnt; d0 = done0_cnt;
    @(posedge clk); #1;
    chk("t6_regrant", rq0_gnt, 1);
    chk("t6_no_gnt1", rq1_gnt, 0);
    @(posedge clk); #1;
    chk("t6_en", txd_en, 1);
    chk("t6_div", tx_div, 8);
    wait_frames(f + 1, 300, "t6_wait");
    rq0_req = 0;
    chk("t6_done0", 64'(done0_cnt - d0), 1);
    @(negedge clk);

    chk("fin_overlap", 64'(ovl), 0);
    chk("fin_loser", 64'(lose_bad), 0);
    chk("fin_div", 64'(div_bad), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
